// File: rtl/obb_frame_scheduler.sv
// Per-frame OBB physics sequencer: owns the body register file, feeds impulses and
// integration steps through the external combinational updater, and serves a render read port.
module obb_frame_scheduler #(
  parameter int unsigned N_BODIES     = 8,
  parameter int unsigned POS_W        = 32,
  parameter int unsigned VEL_W        = 32,
  parameter int unsigned ANG_W        = 32,
  parameter int unsigned DIM_W        = 16,
  parameter int unsigned MAX_IMPULSES = 16,
  localparam int unsigned IDX_W       = (N_BODIES > 1) ? $clog2(N_BODIES) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [POS_W-1:0] load_pos_x, load_pos_y,
  input  logic [VEL_W-1:0] load_vel_x, load_vel_y,
  input  logic [ANG_W-1:0] load_angle, load_omega,
  input  logic [DIM_W-1:0] load_width, load_height,
  input  logic             imp_valid,
  output logic             imp_ready,
  input  logic             imp_last,
  input  logic [IDX_W-1:0] imp_idx,
  input  logic [VEL_W-1:0] imp_x, imp_y,
  output logic             impulse_en,
  output logic             update_en,
  output logic [VEL_W-1:0] upd_imp_x, upd_imp_y,
  output logic [POS_W-1:0] prev_pos_x, prev_pos_y,
  output logic [VEL_W-1:0] prev_vel_x, prev_vel_y,
  output logic [ANG_W-1:0] prev_angle, prev_omega,
  output logic [DIM_W-1:0] prev_width, prev_height,
  input  logic [POS_W-1:0] next_pos_x, next_pos_y,
  input  logic [VEL_W-1:0] next_vel_x, next_vel_y,
  input  logic [ANG_W-1:0] next_angle, next_omega,
  input  logic [DIM_W-1:0] next_width, next_height,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [POS_W-1:0] rd_pos_x, rd_pos_y,
  output logic [VEL_W-1:0] rd_vel_x, rd_vel_y,
  output logic [ANG_W-1:0] rd_angle, rd_omega,
  output logic [DIM_W-1:0] rd_width, rd_height
);

  localparam int unsigned CNT_W = $clog2(MAX_IMPULSES + 1);
  localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N_BODIES);

  typedef struct packed {
    logic [POS_W-1:0] pos_x, pos_y;
    logic [VEL_W-1:0] vel_x, vel_y;
    logic [ANG_W-1:0] angle, omega;
    logic [DIM_W-1:0] width, height;
  } body_t;

  typedef enum logic [1:0] {IDLE, IMPULSE, INTEGRATE, DONE} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, imp_ready_q, imp_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] int_idx_q, int_idx_d, sel_idx;
  body_t            body_q [N_BODIES];
  body_t            body_d [N_BODIES];
  body_t            rd_q, rd_d, prev_b, next_b;
  logic             hs, load_ok, imp_ok, sel_ok, rd_ok;

  assign hs      = (state_q == IMPULSE) && imp_valid && imp_ready_q;
  assign load_ok = {1'b0, load_idx} < N_EXT;
  assign imp_ok  = {1'b0, imp_idx} < N_EXT;
  assign rd_ok   = {1'b0, rd_idx} < N_EXT;
  assign next_b  = '{next_pos_x, next_pos_y, next_vel_x, next_vel_y,
                     next_angle, next_omega, next_width, next_height};

  // Handshake cycles look at the impulse target, INTEGRATE at the sweep index, else body 0.
  always_comb begin
    sel_idx = '0;
    if (hs) sel_idx = imp_idx;
    else if (state_q == INTEGRATE) sel_idx = int_idx_q;
    sel_ok = {1'b0, sel_idx} < N_EXT;
    prev_b = sel_ok ? body_q[sel_idx] : '0;
    rd_d   = rd_ok ? body_q[rd_idx] : '0;
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    imp_ready_d = 1'b0;
    cnt_d       = cnt_q;
    int_idx_d   = int_idx_q;
    body_d      = body_q;
    case (state_q)
      IDLE: begin
        if (load_en && load_ok)
          body_d[load_idx] = '{load_pos_x, load_pos_y, load_vel_x, load_vel_y,
                               load_angle, load_omega, load_width, load_height};
        if (frame_start) begin
          state_d     = IMPULSE;
          busy_d      = 1'b1;
          imp_ready_d = 1'b1;
          cnt_d       = '0;
        end
      end
      IMPULSE: begin
        imp_ready_d = 1'b1;
        if (hs) begin
          if (imp_ok) begin
            body_d[imp_idx].vel_x = next_vel_x;
            body_d[imp_idx].vel_y = next_vel_y;
            body_d[imp_idx].omega = next_omega;
          end
          cnt_d = cnt_q + 1'b1;
          if (imp_last || cnt_q == CNT_W'(MAX_IMPULSES - 1)) begin
            state_d     = INTEGRATE;
            int_idx_d   = '0;
            imp_ready_d = 1'b0;
          end
        end
      end
      INTEGRATE: begin
        body_d[int_idx_q] = next_b;
        if (int_idx_q == IDX_W'(N_BODIES - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          int_idx_d = int_idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      imp_ready_q <= 1'b0;
      cnt_q       <= '0;
      int_idx_q   <= '0;
      rd_q        <= '0;
      for (int unsigned i = 0; i < N_BODIES; i++) body_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      imp_ready_q <= imp_ready_d;
      cnt_q       <= cnt_d;
      int_idx_q   <= int_idx_d;
      rd_q        <= rd_d;
      for (int unsigned i = 0; i < N_BODIES; i++) body_q[i] <= body_d[i];
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign imp_ready  = imp_ready_q;
  assign overrun    = frame_start && busy_q;
  assign impulse_en = hs && imp_ok;
  assign update_en  = (state_q == INTEGRATE);
  assign upd_imp_x  = hs ? imp_x : '0;
  assign upd_imp_y  = hs ? imp_y : '0;

  assign {prev_pos_x, prev_pos_y, prev_vel_x, prev_vel_y,
          prev_angle, prev_omega, prev_width, prev_height} = prev_b;
  assign {rd_pos_x, rd_pos_y, rd_vel_x, rd_vel_y,
          rd_angle, rd_omega, rd_width, rd_height} = rd_q;

endmodule

// File: tb/tb_obb_frame_scheduler.sv
// Directed bench for obb_frame_scheduler with a small stand-in updater whose results are easy to hand-compute.
module tb_obb_frame_scheduler;
  localparam int unsigned N = 6;
  localparam int unsigned IW = 3;

  logic Clk = 1'b0, Reset = 1'b1;
  logic frame_start = 1'b0, busy, done, overrun;
  logic load_en = 1'b0;
  logic [IW-1:0] load_idx = '0, imp_idx = '0, rd_idx = '0;
  logic [31:0] load_pos_x = '0, load_pos_y = '0, load_vel_x = '0, load_vel_y = '0;
  logic [31:0] load_angle = '0, load_omega = '0;
  logic [15:0] load_width = '0, load_height = '0;
  logic imp_valid = 1'b0, imp_ready, imp_last = 1'b0;
  logic [31:0] imp_x = '0, imp_y = '0;
  logic impulse_en, update_en;
  logic [31:0] upd_imp_x, upd_imp_y;
  logic [31:0] prev_pos_x, prev_pos_y, prev_vel_x, prev_vel_y, prev_angle, prev_omega;
  logic [15:0] prev_width, prev_height;
  logic [31:0] next_pos_x, next_pos_y, next_vel_x, next_vel_y, next_angle, next_omega;
  logic [15:0] next_width, next_height;
  logic [31:0] rd_pos_x, rd_pos_y, rd_vel_x, rd_vel_y, rd_angle, rd_omega;
  logic [15:0] rd_width, rd_height;

  int total = 0, bad = 0;

  obb_frame_scheduler #(.N_BODIES(N), .MAX_IMPULSES(16)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .busy(busy), .done(done), .overrun(overrun),
    .load_en(load_en), .load_idx(load_idx), .load_pos_x(load_pos_x), .load_pos_y(load_pos_y),
    .load_vel_x(load_vel_x), .load_vel_y(load_vel_y), .load_angle(load_angle), .load_omega(load_omega),
    .load_width(load_width), .load_height(load_height),
    .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_last(imp_last), .imp_idx(imp_idx),
    .imp_x(imp_x), .imp_y(imp_y), .impulse_en(impulse_en), .update_en(update_en),
    .upd_imp_x(upd_imp_x), .upd_imp_y(upd_imp_y),
    .prev_pos_x(prev_pos_x), .prev_pos_y(prev_pos_y), .prev_vel_x(prev_vel_x), .prev_vel_y(prev_vel_y),
    .prev_angle(prev_angle), .prev_omega(prev_omega), .prev_width(prev_width), .prev_height(prev_height),
    .next_pos_x(next_pos_x), .next_pos_y(next_pos_y), .next_vel_x(next_vel_x), .next_vel_y(next_vel_y),
    .next_angle(next_angle), .next_omega(next_omega), .next_width(next_width), .next_height(next_height),
    .rd_idx(rd_idx), .rd_pos_x(rd_pos_x), .rd_pos_y(rd_pos_y), .rd_vel_x(rd_vel_x), .rd_vel_y(rd_vel_y),
    .rd_angle(rd_angle), .rd_omega(rd_omega), .rd_width(rd_width), .rd_height(rd_height)
  );

  always #5 Clk = ~Clk;

  // Stand-in updater: impulse adds to velocity and bumps omega by 1;
  // integrate steps pos by (+1,+2) and angle by omega.
  always_comb begin
    next_pos_x = prev_pos_x;  next_pos_y = prev_pos_y;
    next_vel_x = prev_vel_x;  next_vel_y = prev_vel_y;
    next_angle = prev_angle;  next_omega = prev_omega;
    next_width = prev_width;  next_height = prev_height;
    if (impulse_en) begin
      next_vel_x = prev_vel_x + upd_imp_x;
      next_vel_y = prev_vel_y + upd_imp_y;
      next_omega = prev_omega + 32'd1;
    end
    if (update_en) begin
      next_pos_x = prev_pos_x + 32'd1;
      next_pos_y = prev_pos_y + 32'd2;
      next_angle = prev_angle + prev_omega;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int i);
    rd_idx = IW'(i);
    tick();
  endtask

  task automatic load(input int i, input logic [31:0] px, py, vx, vy, om, input logic [15:0] w);
    load_en = 1'b1; load_idx = IW'(i);
    load_pos_x = px; load_pos_y = py; load_vel_x = vx; load_vel_y = vy;
    load_angle = '0; load_omega = om; load_width = w; load_height = '0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int ue, done_at, acc, cyc;
    bit done_seen;

    tick(); tick();
    Reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_imp_ready", 32'(imp_ready), 32'd0);
    chk("rst_update_en", 32'(update_en), 32'd0);
    chk("rst_prev_pos_x", prev_pos_x, 32'd0);
    chk("rst_rd_pos_x", rd_pos_x, 32'd0);

    // Load body 2 while reading it: same-edge write not yet visible
    load(2, 32'd10, 32'd20, 32'h0400_0000, 32'd0, 32'd0, 16'd0);
    rd_idx = 3'd2;
    tick();
    load_en = 1'b0;
    chk("rd_same_edge", rd_pos_x, 32'd0);
    tick();
    chk("rd2_pos_x", rd_pos_x, 32'd10);
    chk("rd2_pos_y", rd_pos_y, 32'd20);
    chk("rd2_vel_x", rd_vel_x, 32'h0400_0000);
    rd(3);
    chk("rd3_empty", rd_pos_y, 32'd0);
    rd(7);
    chk("rd_oob", rd_pos_x, 32'd0);

    load(0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 16'd0);          tick();
    load(1, 32'd0, 32'd0, 32'h0100_0000, 32'd0, 32'd0, 16'd0);  tick();
    load(3, 32'd0, 32'd0, 32'd0, 32'h0080_0000, 32'd5, 16'd0);  tick();

    // Frame 1: frame_start together with a load of body 4
    load(4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd7);
    frame_start = 1'b1;
    tick();
    load_en = 1'b0; frame_start = 1'b0;
    chk("f1_busy", 32'(busy), 32'd1);
    chk("f1_imp_ready", 32'(imp_ready), 32'd1);
    imp_valid = 1'b1; imp_last = 1'b1; imp_idx = 3'd1; imp_x = 32'h0200_0000; imp_y = '0;
    #1;
    chk("f1_impulse_en", 32'(impulse_en), 32'd1);
    chk("f1_update_en", 32'(update_en), 32'd0);
    chk("f1_prev_vel_x", prev_vel_x, 32'h0100_0000);
    chk("f1_upd_imp_x", upd_imp_x, 32'h0200_0000);
    tick();
    imp_valid = 1'b0; imp_last = 1'b0;
    chk("f1_ready_drop", 32'(imp_ready), 32'd0);
    ue = 0; done_at = 0;
    for (int k = 1; k <= 12; k++) begin
      if (update_en === 1'b1) ue++;
      if (done === 1'b1 && done_at == 0) done_at = k;
      tick();
    end
    chk("f1_integrate_cycles", 32'(ue), 32'(N));
    chk("f1_done_latency", 32'(done_at), 32'(N + 1));
    chk("f1_busy_after", 32'(busy), 32'd0);
    rd(1);
    chk("f1_b1_vel_x", rd_vel_x, 32'h0300_0000);
    chk("f1_b1_omega", rd_omega, 32'd1);
    chk("f1_b1_angle", rd_angle, 32'd1);
    rd(2);
    chk("f1_b2_pos_x", rd_pos_x, 32'd11);
    rd(4);
    chk("f1_b4_width", 32'(rd_width), 32'd7);

    // Frame 2: back-to-back impulses to body 3, overrun during INTEGRATE
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    imp_valid = 1'b1; imp_idx = 3'd3; imp_x = '0; imp_y = 32'h0400_0000;
    #1;
    chk("f2_ready_1", 32'(imp_ready), 32'd1);
    chk("f2_prev_vel_y_1", prev_vel_y, 32'h0080_0000);
    tick();
    imp_last = 1'b1;
    #1;
    chk("f2_ready_2", 32'(imp_ready), 32'd1);
    chk("f2_prev_vel_y_2", prev_vel_y, 32'h0480_0000);
    chk("f2_prev_omega_2", prev_omega, 32'd6);
    tick();
    imp_valid = 1'b0; imp_last = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 12; k++) begin
      frame_start = (k == 3);
      #1;
      if (k == 1) chk("f2_no_overrun", 32'(overrun), 32'd0);
      if (k == 3) chk("f2_overrun", 32'(overrun), 32'd1);
      if (done === 1'b1 && done_at == 0) done_at = k;
      tick();
    end
    frame_start = 1'b0;
    chk("f2_done_latency", 32'(done_at), 32'(N + 1));
    chk("f2_not_restarted", 32'(busy), 32'd0);
    rd(3);
    chk("f2_b3_vel_y", rd_vel_y, 32'h0880_0000);
    chk("f2_b3_angle", rd_angle, 32'd12);

    // Frame 3: impulse to a nonexistent body; load attempted mid-frame
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    imp_valid = 1'b1; imp_last = 1'b1; imp_idx = 3'(N); imp_x = 32'd7; imp_y = '0;
    #1;
    chk("f3_impulse_en", 32'(impulse_en), 32'd0);
    chk("f3_ready", 32'(imp_ready), 32'd1);
    tick();
    imp_valid = 1'b0; imp_last = 1'b0;
    chk("f3_handshake_done", 32'(imp_ready), 32'd0);
    load(0, 32'd0, 32'd0, 32'hDEAD, 32'd0, 32'd0, 16'd0);
    wait_done(cyc);
    chk("f3_done", 32'(done), 32'd1);
    load_en = 1'b0;
    tick();
    rd(1);
    chk("f3_b1_vel_x", rd_vel_x, 32'h0300_0000);
    chk("f3_b1_omega", rd_omega, 32'd1);
    rd(0);
    chk("f3_b0_vel_x", rd_vel_x, 32'd0);

    // Frame 4: 20 impulses offered without imp_last, capped at 16
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    imp_idx = 3'd5; imp_x = 32'd1; imp_y = '0;
    acc = 0;
    for (int k = 1; k <= 20; k++) begin
      imp_valid = 1'b1;
      #1;
      if (imp_ready === 1'b1) acc++;
      if (k == 17) chk("f4_ready_17", 32'(imp_ready), 32'd0);
      tick();
    end
    imp_valid = 1'b0;
    chk("f4_accepted", 32'(acc), 32'd16);
    wait_done(cyc);
    chk("f4_done", 32'(done), 32'd1);
    tick();
    rd(5);
    chk("f4_b5_vel_x", rd_vel_x, 32'd16);
    chk("f4_b5_omega", rd_omega, 32'd16);

    // Frame 5: reset mid-INTEGRATE
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    imp_valid = 1'b1; imp_last = 1'b1; imp_idx = 3'd0; imp_x = 32'd3;
    tick();
    imp_valid = 1'b0; imp_last = 1'b0;
    tick();
    chk("f5_in_integrate", 32'(update_en), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("f5_busy_cleared", 32'(busy), 32'd0);
    chk("f5_update_en", 32'(update_en), 32'd0);
    chk("f5_rd_cleared", rd_pos_x, 32'd0);
    done_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1) done_seen = 1'b1;
      tick();
    end
    chk("f5_no_done", 32'(done_seen), 32'd0);
    rd(2);
    chk("f5_b2_pos_x", rd_pos_x, 32'd0);
    rd(3);
    chk("f5_b3_vel_y", rd_vel_y, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
